// File: rtl/vga_timing_pkg.sv
// Horizontal timing defaults, lock-state encoding and counter helpers shared by
// the hsync lock logic and the hsync generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 200;
    localparam int DEF_H_FP       = 10;
    localparam int DEF_H_SYNC     = 32;
    localparam int DEF_H_BP       = 22;
    localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_LOCK_LINES = 4;
    localparam int CNT_W          = 9;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers the sync input, flags its leading edge one clock later and measures
// the width of the most recently completed sync pulse.
module sync_edge_det
    import vga_timing_pkg::*;
#(
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_in,
    output logic             lead_edge,
    output logic [CNT_W-1:0] last_width
);

    logic             samp_r;
    logic             samp_d_r;
    logic             edge_r;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] last_width_r;
    logic             asserted_s;
    logic             rise_s;
    logic             fall_s;

    // Samples are normalised to "asserted = 1" before any history is kept.
    assign asserted_s = (sync_in == SYNC_POL);
    assign rise_s     = samp_r & ~samp_d_r;
    assign fall_s     = ~samp_r & samp_d_r;

    // Sync history, registered edge pulse and pulse-width measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_r       <= 1'b0;
            samp_d_r     <= 1'b0;
            edge_r       <= 1'b0;
            width_r      <= {CNT_W{1'b0}};
            last_width_r <= {CNT_W{1'b0}};
        end else begin
            samp_r   <= asserted_s;
            samp_d_r <= samp_r;
            edge_r   <= rise_s;
            if (rise_s) begin
                width_r <= CNT_W'(1);
            end else if (samp_r) begin
                width_r <= sat_inc(width_r);
            end else begin
                width_r <= width_r;
            end
            if (fall_s) begin
                last_width_r <= width_r;
            end else begin
                last_width_r <= last_width_r;
            end
        end
    end

    assign lead_edge  = edge_r;
    assign last_width = last_width_r;

endmodule

// File: rtl/hsync_lock.sv
// Horizontal sync lock: qualifies incoming hsync timing, then free-runs a column
// counter that trails the transmitter column by exactly two clocks.
module hsync_lock
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int LOCK_LINES = DEF_LOCK_LINES,
    parameter bit HSYNC_POL  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       hblank_n,
    output logic       locked,
    output logic [8:0] x,
    output logic       active,
    output logic       line_start,
    output logic       err,
    output logic [8:0] period
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int GOOD_W  = $clog2(LOCK_LINES + 1);

    localparam logic [CNT_W-1:0]  LAST_X_C  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0]  ACTIVE_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  SYNC_C    = CNT_W'(H_SYNC);
    // The registered edge is consumed on the clock that moves x onto this column.
    localparam logic [CNT_W-1:0]  EDGE_X_C  = CNT_W'(H_ACTIVE + H_FP + 1);
    localparam logic [CNT_W-1:0]  PRE_SAT_C = CNT_W'((1 << CNT_W) - 2);
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_LINES);

    lock_state_t       state_r, state_nx_s;
    logic [CNT_W-1:0]  x_r, x_nx_s, x_step_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [CNT_W-1:0]  period_r, period_nx_s;
    logic [GOOD_W-1:0] good_r, good_nx_s, good_inc_s;
    logic              bad_r, bad_nx_s;
    logic              err_nx_s;
    logic              locked_r, active_r, line_start_r, err_r;
    logic              hblank_r, hblank_d_r;
    logic              lead_edge_s;
    logic [CNT_W-1:0]  last_width_s;
    logic              line_ok_s, pos_ok_s, blank_bad_s, timeout_s;

    sync_edge_det #(
        .SYNC_POL (HSYNC_POL)
    ) u_edge_det (
        .clk        (clk),
        .reset      (reset),
        .sync_in    (hsync),
        .lead_edge  (lead_edge_s),
        .last_width (last_width_s)
    );

    assign x_step_s    = (x_r == LAST_X_C) ? {CNT_W{1'b0}} : x_r + CNT_W'(1);
    assign good_inc_s  = good_r + GOOD_W'(1);
    assign line_ok_s   = (cnt_r == TOTAL_C) && (last_width_s == SYNC_C);
    assign pos_ok_s    = (x_step_s == EDGE_X_C) && (last_width_s == SYNC_C);
    // hblank_d_r is two clocks old, the same age as the column held in x_r.
    assign blank_bad_s = (hblank_d_r != (x_r < ACTIVE_C));
    assign timeout_s   = !lead_edge_s && (cnt_r == PRE_SAT_C);

    // Next-state, column, line-quality and error decisions.
    always_comb begin
        state_nx_s  = state_r;
        x_nx_s      = {CNT_W{1'b0}};
        good_nx_s   = good_r;
        bad_nx_s    = bad_r;
        err_nx_s    = 1'b0;
        cnt_nx_s    = sat_inc(cnt_r);
        period_nx_s = period_r;
        if (lead_edge_s) begin
            cnt_nx_s    = CNT_W'(1);
            period_nx_s = cnt_r;
        end else begin
            cnt_nx_s    = sat_inc(cnt_r);
        end
        if (timeout_s) begin
            err_nx_s   = 1'b1;
            state_nx_s = ST_SEARCH;
            bad_nx_s   = 1'b0;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    if (lead_edge_s) begin
                        state_nx_s = ST_ACQUIRE;
                        good_nx_s  = {GOOD_W{1'b0}};
                    end else begin
                        state_nx_s = ST_SEARCH;
                    end
                end
                ST_ACQUIRE: begin
                    if (!lead_edge_s) begin
                        good_nx_s = good_r;
                    end else if (!line_ok_s) begin
                        good_nx_s = {GOOD_W{1'b0}};
                    end else if (good_inc_s == LOCK_C) begin
                        state_nx_s = ST_LOCKED;
                        x_nx_s     = EDGE_X_C;
                        good_nx_s  = {GOOD_W{1'b0}};
                        bad_nx_s   = 1'b0;
                    end else begin
                        good_nx_s  = good_inc_s;
                    end
                end
                ST_LOCKED: begin
                    x_nx_s   = x_step_s;
                    err_nx_s = blank_bad_s;
                    if (!lead_edge_s) begin
                        bad_nx_s = bad_r;
                    end else if (pos_ok_s) begin
                        bad_nx_s = 1'b0;
                    end else if (bad_r) begin
                        err_nx_s   = 1'b1;
                        state_nx_s = ST_SEARCH;
                        x_nx_s     = {CNT_W{1'b0}};
                        bad_nx_s   = 1'b0;
                    end else begin
                        err_nx_s   = 1'b1;
                        bad_nx_s   = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = ST_SEARCH;
                    good_nx_s  = {GOOD_W{1'b0}};
                    bad_nx_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_SEARCH;
            x_r          <= {CNT_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            period_r     <= {CNT_W{1'b0}};
            good_r       <= {GOOD_W{1'b0}};
            bad_r        <= 1'b0;
            locked_r     <= 1'b0;
            active_r     <= 1'b0;
            line_start_r <= 1'b0;
            err_r        <= 1'b0;
            hblank_r     <= 1'b0;
            hblank_d_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            x_r          <= x_nx_s;
            cnt_r        <= cnt_nx_s;
            period_r     <= period_nx_s;
            good_r       <= good_nx_s;
            bad_r        <= bad_nx_s;
            locked_r     <= (state_nx_s == ST_LOCKED);
            active_r     <= (state_nx_s == ST_LOCKED) && (x_nx_s < ACTIVE_C);
            line_start_r <= (state_nx_s == ST_LOCKED) && (x_nx_s == {CNT_W{1'b0}});
            err_r        <= err_nx_s;
            hblank_r     <= hblank_n;
            hblank_d_r   <= hblank_r;
        end
    end

    assign locked     = locked_r;
    assign x          = x_r;
    assign active     = active_r;
    assign line_start = line_start_r;
    assign err        = err_r;
    assign period     = period_r;

endmodule

// File: tb/tb_hsync_lock.sv
// Directed bench for hsync_lock: a behavioural hsync generator with hooks to
// shift, suppress or corrupt individual lines.
module tb_hsync_lock;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       hblank_n;
    logic       locked;
    logic [8:0] x;
    logic       active;
    logic       line_start;
    logic       err;
    logic [8:0] period;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit gen_run    = 1'b0;
    bit sync_kill  = 1'b0;
    int sync_start = 210;
    int glitch_req = 0;

    int gen_col = 0, col_now = 0, col_d1 = 0, col_d2 = 0;
    int edge_num = 0, last_edge_cyc = -1000, glitch_cyc = -1, glitch_done = 0;
    bit in_sync = 1'b0, prev_sync = 1'b0;

    hsync_lock dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .hblank_n   (hblank_n),
        .locked     (locked),
        .x          (x),
        .active     (active),
        .line_start (line_start),
        .err        (err),
        .period     (period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: one column per clock, 264 columns per line.
    initial begin
        hsync    = 1'b0;
        hblank_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_run) begin
                col_d2  = col_d1;
                col_d1  = col_now;
                col_now = gen_col;
                gen_col = (gen_col == 263) ? 0 : gen_col + 1;
                in_sync = !sync_kill && (col_now >= sync_start) && (col_now < sync_start + 32);
                if (in_sync && !prev_sync) begin
                    edge_num++;
                    last_edge_cyc = cyc;
                end
                prev_sync = in_sync;
                hsync     = in_sync;
                hblank_n  = (col_now < 200);
                if (glitch_req != glitch_done && col_now == 50) begin
                    hblank_n    = 1'b0;
                    glitch_done = glitch_req;
                    glitch_cyc  = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic wait_col(input int c);
        int hit = 0;
        for (int i = 0; i < 600 && hit == 0; i++) begin
            @(negedge clk);
            if (col_now == c) hit = 1;
        end
        if (hit == 0) chk("wait_col", hit, 1);
    endtask

    task automatic wait_lock(input string tag, input int base);
        int seen = 0;
        for (int i = 0; i < 3000 && seen == 0; i++) begin
            @(negedge clk);
            if (locked) seen = 1;
        end
        chk({tag, "_locked"}, seen, 1);
        chk({tag, "_edges"}, edge_num - base, 5);
        chk({tag, "_latency"}, cyc - last_edge_cyc, 3);
        chk({tag, "_x"}, int'(x), 211);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_active"}, int'(active), 0);
        chk({tag, "_line_start"}, int'(line_start), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_period"}, int'(period), 0);
    endtask

    initial begin
        int xbad, ls, act, errs, wraps, prev_x, lk, zeros, lk_a, err_at, hit, xv;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset   = 1'b0;
        gen_run = 1'b1;

        wait_lock("lock", 0);
        chk("period_locked", int'(period), 264);

        // Two full lines of free-running lock.
        xbad = 0; ls = 0; act = 0; errs = 0; wraps = 0; prev_x = int'(x);
        for (int i = 0; i < 528; i++) begin
            @(negedge clk);
            if (int'(x) != col_d2) xbad++;
            ls    += int'(line_start);
            act   += int'(active);
            errs  += int'(err);
            if (prev_x == 263 && int'(x) == 0) wraps++;
            prev_x = int'(x);
        end
        chk("x_tracks_col", xbad, 0);
        chk("line_start_count", ls, 2);
        chk("active_count", act, 400);
        chk("run_err_count", errs, 0);
        chk("wrap_count", wraps, 2);

        // One short line (263) followed by a long one restoring phase.
        wait_col(0);
        sync_start = 209;
        errs = 0; lk = 1;
        for (int i = 0; i < 528; i++) begin
            @(negedge clk);
            if (col_now == 0) sync_start = 210;
            errs += int'(err);
            lk   &= int'(locked);
        end
        chk("short_line_errs", errs, 1);
        chk("short_line_locked", lk, 1);

        // Two consecutive bad lines drop lock.
        wait_col(0);
        sync_start = 209;
        errs = 0; zeros = 0; lk_a = 0;
        for (int i = 0; i < 528; i++) begin
            @(negedge clk);
            if (col_now == 0) begin
                zeros++;
                sync_start = (zeros == 1) ? 208 : 210;
            end
            if (zeros == 0 && col_now == 230) lk_a = int'(locked);
            errs += int'(err);
        end
        chk("bad1_still_locked", lk_a, 1);
        chk("bad2_errs", errs, 2);
        chk("bad2_unlocked", int'(locked), 0);
        wait_lock("relock_bad", edge_num);

        // Single-clock hblank glitch at column 50.
        wait_col(0);
        glitch_req++;
        errs = 0; err_at = -1;
        for (int i = 0; i < 264; i++) begin
            @(negedge clk);
            if (err && err_at < 0) err_at = cyc;
            errs += int'(err);
        end
        chk("glitch_err_delay", err_at - glitch_cyc, 3);
        chk("glitch_err_count", errs, 1);
        chk("glitch_locked", int'(locked), 1);

        // hsync suppressed: saturation timeout.
        wait_col(0);
        sync_kill = 1'b1;
        hit = 0; err_at = -1; lk = 1; xv = -1;
        for (int i = 0; i < 700 && hit == 0; i++) begin
            @(negedge clk);
            if (err) begin
                hit = 1; err_at = cyc; lk = int'(locked); xv = int'(x);
            end
        end
        chk("timeout_seen", hit, 1);
        chk("timeout_delay", err_at - last_edge_cyc, 513);
        chk("timeout_locked", lk, 0);
        chk("timeout_x", xv, 0);
        wait_col(0);
        sync_kill = 1'b0;
        wait_lock("relock_timeout", edge_num);

        // Reset mid-line while locked.
        wait_col(50);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midline_reset");
        reset = 1'b0;
        wait_lock("relock_reset", edge_num);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
